// File: rtl/noc_pkg.sv
// Shared NoC definitions: address field layout, packet view, port directions.
// Imported by the router input port and its interface.
package noc_pkg;

  localparam int ADDR_W    = 8;
  localparam int ADDR_X_HI = 7;
  localparam int ADDR_X_LO = 4;
  localparam int ADDR_Y_HI = 3;
  localparam int ADDR_Y_LO = 0;
  localparam int DROP_W    = 8;

  typedef struct packed {
    logic [23:0] payload;
    logic [3:0]  x;
    logic [3:0]  y;
  } packet_t;

  typedef enum logic [2:0] {
    SOUTH,
    EAST,
    WEST,
    LOCAL,
    NORTH
  } dir_e;

  function automatic logic [ADDR_W-1:0] pkt_addr(
    input packet_t p
  );
    return {p.x, p.y};
  endfunction

endpackage

// File: rtl/router_input_port_if.sv
// Link + head-of-line bundle of one router input port.
// master: neighbour/controller side; slave: the input port.
interface router_input_port_if
  import noc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] data_i;
  logic              valid_i;
  logic              full_o;
  logic [DATA_W-1:0] head_data_o;
  logic [ADDR_W-1:0] head_addr_o;
  logic              head_valid_o;
  logic              pop_i;
  logic [CNT_W-1:0]  count_o;
  logic [DROP_W-1:0] drop_cnt_o;

  modport master (
    output data_i, valid_i, pop_i,
    input  full_o, head_data_o, head_addr_o,
    input  head_valid_o, count_o, drop_cnt_o
  );

  modport slave (
    input  data_i, valid_i, pop_i,
    output full_o, head_data_o, head_addr_o,
    output head_valid_o, count_o, drop_cnt_o
  );
endinterface

// File: rtl/router_input_port.sv
// Router input FIFO: queues neighbour packets, exposes head addr/valid, pops on grant.
// Ports: clk, rst (async active low), port (router_input_port_if.slave); option ROUTER_INPUT_BYPASS_EN.
module router_input_port
  import noc_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input logic                clk,
  input logic                rst,
  router_input_port_if.slave port
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              hv_q, hv_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic              fwd;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head_data;
  logic              head_valid;

  always_comb begin
    fwd = 1'b0;
`ifdef ROUTER_INPUT_BYPASS_EN
    // empty queue + grant: packet goes straight through, never stored
    fwd = ~hv_q & port.valid_i & port.pop_i;
`endif
    // full is registered: a same-cycle pop does not free a slot
    push = port.valid_i & ~full_q & ~fwd;
    pop  = port.pop_i & hv_q;

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = port.data_i;

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    full_d   = (count_d == CNT_W'(DEPTH));
    hv_d     = (count_d != '0);

    drop_d = drop_q;
    if (port.valid_i & full_q & (drop_q != '1))
      drop_d = drop_q + 1'b1;

    head_data  = mem_q[rd_ptr_q];
    head_valid = hv_q;
`ifdef ROUTER_INPUT_BYPASS_EN
    if (~hv_q & port.valid_i) begin
      head_data  = port.data_i;
      head_valid = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      hv_q     <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      hv_q     <= hv_d;
      drop_q   <= drop_d;
    end
  end

  // storage is deliberately not reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign port.full_o       = full_q;
  assign port.head_data_o  = head_data;
  assign port.head_addr_o  = head_data[ADDR_W-1:0];
  assign port.head_valid_o = head_valid;
  assign port.count_o      = count_q;
  assign port.drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_router_input_port.sv
// Bench for router_input_port: vector table for occupancy/flags,
// scoreboard queue for head-of-line data order.
module tb_router_input_port;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  router_input_port_if #(.DATA_W(32), .DEPTH(4)) pif ();

  router_input_port #(.DEPTH(4), .DATA_W(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .port (pif)
  );

  typedef struct {
    bit          v;
    bit          p;
    logic [31:0] d;
    int          cnt;
    bit          full;
    bit          hv;
    int          drop;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] mq[$];
  int          mdrop = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit v, bit p, logic [31:0] d, int c,
                              bit f, bit h, int dr);
    vec_t r;
    r.v = v; r.p = p; r.d = d; r.cnt = c;
    r.full = f; r.hv = h; r.drop = dr;
    return r;
  endfunction

  // one cycle: drive, check head before edge, update model, settle after edge
  task automatic step(input bit v, input bit p, input logic [31:0] d);
    logic [31:0] eh;
    bit          full;
    bit          byp;
    bit          acc;
    pif.valid_i = v;
    pif.pop_i   = p;
    pif.data_i  = d;
    @(negedge clk);
    if (mq.size() > 0) begin
      eh = mq[0];
      chk("head_valid", 32'(pif.head_valid_o), 32'd1);
      chk("head_data", pif.head_data_o, eh);
      chk("head_addr", 32'(pif.head_addr_o), 32'(eh[7:0]));
    end else if (v) begin
`ifdef ROUTER_INPUT_BYPASS_EN
      chk("byp_valid", 32'(pif.head_valid_o), 32'd1);
      chk("byp_data", pif.head_data_o, d);
`else
      chk("head_valid_lat", 32'(pif.head_valid_o), 32'd0);
`endif
    end else begin
      chk("head_valid_empty", 32'(pif.head_valid_o), 32'd0);
    end
    full = (mq.size() == 4);
    byp  = 1'b0;
`ifdef ROUTER_INPUT_BYPASS_EN
    byp = (mq.size() == 0) && v && p;
`endif
    acc = v && !full && !byp;
    if (v && full && mdrop < 255) mdrop++;
    if (p && mq.size() > 0) void'(mq.pop_front());
    if (acc) mq.push_back(d);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string nm, input int c, input bit f,
                           input bit h, input int dr);
    chk({nm, "_count"}, 32'(pif.count_o), 32'(c));
    chk({nm, "_full"}, 32'(pif.full_o), 32'(f));
    chk({nm, "_hv"}, 32'(pif.head_valid_o), 32'(h));
    chk({nm, "_drop"}, 32'(pif.drop_cnt_o), 32'(dr));
  endtask

  initial begin
    pif.valid_i = 1'b0;
    pif.pop_i   = 1'b0;
    pif.data_i  = '0;

    // basic order
    vecs.push_back(mk(1, 0, 32'hA000_0011, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 32'hA000_0022, 2, 0, 1, 0));
    vecs.push_back(mk(1, 0, 32'hA000_0033, 3, 0, 1, 0));
    vecs.push_back(mk(0, 1, 32'h0,         2, 0, 1, 0));
    vecs.push_back(mk(0, 1, 32'h0,         1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 32'h0,         0, 0, 0, 0));
    // fill past depth
    vecs.push_back(mk(1, 0, 32'hB000_0041, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 32'hB000_0042, 2, 0, 1, 0));
    vecs.push_back(mk(1, 0, 32'hB000_0043, 3, 0, 1, 0));
    vecs.push_back(mk(1, 0, 32'hB000_0044, 4, 1, 1, 0));
    vecs.push_back(mk(1, 0, 32'hB000_0045, 4, 1, 1, 1));
    vecs.push_back(mk(1, 0, 32'hB000_0046, 4, 1, 1, 2));
    // pop+push while full: push refused
    vecs.push_back(mk(1, 1, 32'hC000_0050, 3, 0, 1, 3));
    vecs.push_back(mk(0, 1, 32'h0,         2, 0, 1, 3));
    vecs.push_back(mk(0, 1, 32'h0,         1, 0, 1, 3));
    vecs.push_back(mk(0, 1, 32'h0,         0, 0, 0, 3));

    #12;
    chk_state("reset", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].p, vecs[i].d);
      chk_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].full,
                vecs[i].hv, vecs[i].drop);
    end

    // streaming push+pop wraps pointers
    step(1, 0, 32'hD000_0000);
    for (int i = 1; i <= 10; i++) begin
      step(1, 1, 32'hD000_0000 + 32'(i));
      chk("stream_count", 32'(pif.count_o), 32'd1);
    end
    step(0, 1, 32'h0);
    chk_state("stream_end", 0, 0, 0, 3);

    // pop while empty is ignored
    step(0, 1, 32'h0);
    step(0, 1, 32'h0);
    chk_state("pop_empty", 0, 0, 0, 3);

    // drop counter saturation
    for (int i = 0; i < 4; i++) step(1, 0, 32'hE000_0000 + 32'(i));
    for (int i = 0; i < 300; i++) step(1, 0, 32'hF000_0000 + 32'(i));
    chk_state("drop_sat", 4, 1, 1, 255);
    chk("drop_model", 32'(pif.drop_cnt_o), 32'(mdrop));

    // async reset mid-stream
    step(0, 1, 32'h0);
    chk("pre_rst_count", 32'(pif.count_o), 32'd3);
    #2;
    rst = 1'b0;
    #1;
    chk_state("async_rst", 0, 0, 0, 0);
    mq.delete();
    mdrop = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // recovery; stale storage must not reappear
    step(1, 0, 32'hA100_0077);
    chk_state("post_rst", 1, 0, 1, 0);
    step(0, 1, 32'h0);
    chk_state("post_rst_pop", 0, 0, 0, 0);

`ifdef ROUTER_INPUT_BYPASS_EN
    step(1, 1, 32'h9900_0099);
    chk_state("bypass", 0, 0, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
